mmio_byte_port: RTL and testbench

//   Memory-mapped byte I/O responder on the processor address/data bus; answers the CPU's mem_read/mem_write.
//   CPU writes to DATA push a TX FIFO drained by an external byte sink (valid/ready).
//   An external byte source fills an RX FIFO (valid/ready) that CPU reads of DATA pop.

---
 rtl/mmio_byte_port.sv | 129 ++++++++++++
 tb/tb_mmio_byte_port.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_byte_port.sv
// Memory-mapped byte port: a 4-byte register window that bridges CPU bus accesses
// to a TX FIFO (drained by a valid/ready sink) and an RX FIFO (filled by a valid/ready source).
module mmio_byte_port #(
  parameter logic [15:0] BASE_ADDR  = 16'hFF00,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] address_bus,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        irq
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  logic [CW-1:0] tx_count, rx_count;
  logic [1:0]    ctrl;
  logic          tx_ovf, rx_unf;
  logic          irq_p1;

  logic       hit, bus_wr, bus_rd;
  logic       tx_full, tx_empty, rx_full, rx_nonempty;
  logic       tx_push_req, tx_push, tx_pop;
  logic       rx_pop_req, rx_pop, rx_push;
  logic       tx_ovf_set, rx_unf_set, ctrl_wr, clr_wr;
  logic [7:0] status, rd_val;

  function automatic logic [CW-1:0] next_count(logic [CW-1:0] cnt, logic inc, logic dec);
    case ({inc, dec})
      2'b10:   return cnt + 1'b1;
      2'b01:   return cnt - 1'b1;
      default: return cnt;
    endcase
  endfunction

  // A simultaneous read+write strobe is treated as a write only.
  assign hit    = (address_bus[15:2] == BASE_ADDR[15:2]);
  assign bus_wr = hit && mem_write;
  assign bus_rd = hit && mem_read && !mem_write;

  assign tx_full     = (tx_count == FULL_CNT);
  assign tx_empty    = (tx_count == '0);
  assign rx_full     = (rx_count == FULL_CNT);
  assign rx_nonempty = (rx_count != '0);

  assign tx_valid = !tx_empty;
  assign tx_data  = tx_mem[tx_rd_ptr];
  assign rx_ready = !rx_full;

  // A full TX FIFO still accepts a push when the sink frees a slot in the same cycle.
  assign tx_pop      = tx_valid && tx_ready;
  assign tx_push_req = bus_wr && (address_bus[1:0] == 2'd0);
  assign tx_push     = tx_push_req && (!tx_full || tx_pop);
  assign tx_ovf_set  = tx_push_req && !tx_push;

  assign rx_push    = rx_valid && rx_ready;
  assign rx_pop_req = bus_rd && (address_bus[1:0] == 2'd0);
  assign rx_pop     = rx_pop_req && rx_nonempty;
  assign rx_unf_set = rx_pop_req && !rx_nonempty;

  assign ctrl_wr = bus_wr && (address_bus[1:0] == 2'd2);
  assign clr_wr  = bus_wr && (address_bus[1:0] == 2'd3);

  assign status  = {3'b000, tx_ovf, rx_unf, tx_empty, tx_full, rx_nonempty};
  assign data_oe = bus_rd;
  assign irq     = irq_p1;

  always_comb begin
    rd_val = 8'h00;
    case (address_bus[1:0])
      2'd0:    rd_val = rx_nonempty ? rx_mem[rx_rd_ptr] : 8'h00;
      2'd1:    rd_val = status;
      2'd2:    rd_val = {6'b000000, ctrl};
      default: rd_val = 8'h00;
    endcase
    data_out = data_oe ? rd_val : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= data_in;
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      tx_count  <= '0;
      rx_count  <= '0;
      ctrl      <= 2'b00;
      tx_ovf    <= 1'b0;
      rx_unf    <= 1'b0;
      irq_p1    <= 1'b0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      tx_count <= next_count(tx_count, tx_push, tx_pop);
      rx_count <= next_count(rx_count, rx_push, rx_pop);
      if (ctrl_wr) ctrl <= data_in[1:0];
      // Sticky flags: a set in the same cycle as a CLEAR wins.
      if (tx_ovf_set)                tx_ovf <= 1'b1;
      else if (clr_wr && data_in[1]) tx_ovf <= 1'b0;
      if (rx_unf_set)                rx_unf <= 1'b0 | 1'b1;
      else if (clr_wr && data_in[0]) rx_unf <= 1'b0;
      // irq_p1: registered one cycle behind the FIFO counts and enables
      irq_p1 <= (rx_nonempty && ctrl[0]) || (tx_empty && ctrl[1]);
    end
  end

endmodule

// File: tb/tb_mmio_byte_port.sv
// Bench for mmio_byte_port: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_mmio_byte_port;

  localparam logic [15:0] BASE = 16'hFF00;
  localparam int          DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] address_bus;
  logic        mem_read, mem_write;
  logic [7:0]  data_in, data_out;
  logic        data_oe;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  mmio_byte_port #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .address_bus(address_bus), .mem_read(mem_read),
    .mem_write(mem_write), .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic       m_tx_ovf, m_rx_unf, m_irq;
  logic [1:0] m_ctrl;
  bit         model_ok = 0;

  function automatic logic [7:0] model_status();
    return {3'b000, m_tx_ovf, m_rx_unf, txq.size() == 0, txq.size() == DEPTH, rxq.size() != 0};
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (!reset) begin
        txq.delete();
        rxq.delete();
        m_tx_ovf = 0; m_rx_unf = 0; m_irq = 0; m_ctrl = 2'b00;
        model_ok = 1;
      end else if (model_ok) begin
        logic hit, wr, rd, sink_pop, tx_push_ok, rd_data, rx_pop, rx_push, irq_next;
        int   tsz, rsz;
        tsz = txq.size();
        rsz = rxq.size();
        irq_next = (rsz != 0 && m_ctrl[0]) || (tsz == 0 && m_ctrl[1]);
        hit = (address_bus[15:2] == BASE[15:2]);
        wr  = hit && mem_write;
        rd  = hit && mem_read && !mem_write;
        sink_pop = (tsz != 0) && tx_ready;
        rd_data  = rd && address_bus[1:0] == 2'd0;
        rx_pop   = rd_data && rsz != 0;
        rx_push  = rx_valid && (rsz < DEPTH);
        tx_push_ok = (tsz < DEPTH) || sink_pop;
        if (sink_pop) void'(txq.pop_front());
        if (wr && address_bus[1:0] == 2'd0) begin
          if (tx_push_ok) txq.push_back(data_in);
          else m_tx_ovf = 1;
        end
        if (rx_pop) void'(rxq.pop_front());
        if (rx_push) rxq.push_back(rx_data);
        if (rd_data && rsz == 0) m_rx_unf = 1;
        if (wr && address_bus[1:0] == 2'd2) m_ctrl = data_in[1:0];
        if (wr && address_bus[1:0] == 2'd3) begin
          if (data_in[0] && !(rd_data && rsz == 0)) m_rx_unf = 0;
          if (data_in[1] && !(wr && address_bus[1:0] == 2'd0 && !tx_push_ok)) m_tx_ovf = 0;
        end
        m_irq = irq_next;
      end
    end
  end

  // Every-cycle comparison against the model, mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      if (model_ok) begin
        logic       e_oe;
        logic [7:0] e_val;
        e_oe = (address_bus[15:2] == BASE[15:2]) && mem_read && !mem_write;
        case (address_bus[1:0])
          2'd0:    e_val = (rxq.size() != 0) ? rxq[0] : 8'h00;
          2'd1:    e_val = model_status();
          2'd2:    e_val = {6'b0, m_ctrl};
          default: e_val = 8'h00;
        endcase
        if (!e_oe) e_val = 8'h00;
        check("m_data_oe", 32'(data_oe), 32'(e_oe));
        check("m_data_out", 32'(data_out), 32'(e_val));
        check("m_tx_valid", 32'(tx_valid), 32'(txq.size() != 0));
        if (txq.size() != 0) check("m_tx_data", 32'(tx_data), 32'(txq[0]));
        check("m_rx_ready", 32'(rx_ready), 32'(rxq.size() < DEPTH));
        check("m_irq", 32'(irq), 32'(m_irq));
      end
    end
  end

  // Stimulus tasks: each is entered and left just after a rising edge
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    address_bus = a; data_in = d; mem_write = 1'b1;
    tick(1);
    mem_write = 1'b0; address_bus = 16'h0000;
  endtask

  task automatic cpu_both(input logic [15:0] a, input logic [7:0] d);
    address_bus = a; data_in = d; mem_write = 1'b1; mem_read = 1'b1;
    tick(1);
    mem_write = 1'b0; mem_read = 1'b0; address_bus = 16'h0000;
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
    address_bus = a; mem_read = 1'b1;
    @(negedge clk);
    d = data_out;
    @(posedge clk); #1;
    mem_read = 1'b0; address_bus = 16'h0000;
  endtask

  task automatic src_push(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
  endtask

  logic [7:0] rd;

  initial begin
    reset = 1'b0; address_bus = 16'h0000; mem_read = 0; mem_write = 0; data_in = 8'h00;
    tx_ready = 0; rx_data = 8'h00; rx_valid = 0;
    tick(3);
    reset = 1'b1;
    check("rst_tx_valid", 32'(tx_valid), 0);
    check("rst_rx_ready", 32'(rx_ready), 1);
    check("rst_data_oe", 32'(data_oe), 0);
    check("rst_data_out", 32'(data_out), 0);
    check("rst_irq", 32'(irq), 0);

    // TX path: two writes, then drain
    cpu_write(BASE, 8'hA5);
    check("tx_lat_valid", 32'(tx_valid), 1);
    check("tx_head_a5", 32'(tx_data), 32'h A5);
    cpu_write(BASE, 8'h3C);
    check("tx_head_still_a5", 32'(tx_data), 32'hA5);
    tx_ready = 1'b1;
    tick(1);
    check("tx_head_3c", 32'(tx_data), 32'h3C);
    tick(1);
    check("tx_drained", 32'(tx_valid), 0);
    tx_ready = 1'b0;

    // RX path: fill, then read back in order
    for (int i = 0; i < DEPTH; i++) begin
      check("rx_ready_before_full", 32'(rx_ready), 1);
      src_push(8'(i + 1));
    end
    check("rx_ready_full", 32'(rx_ready), 0);
    cpu_read(BASE + 16'd1, rd);
    check("status_rx_full", 32'(rd), 32'h05);
    for (int i = 0; i < DEPTH; i++) begin
      cpu_read(BASE, rd);
      check("rx_order", 32'(rd), 32'(i + 1));
      if (i == 0) check("rx_ready_after_pop", 32'(rx_ready), 1);
    end

    // Underflow and CLEAR
    cpu_read(BASE, rd);
    check("rx_unf_data", 32'(rd), 32'h00);
    cpu_read(BASE + 16'd1, rd);
    check("status_unf", 32'(rd), 32'h0C);
    cpu_write(BASE + 16'd3, 8'h01);
    cpu_read(BASE + 16'd1, rd);
    check("status_cleared", 32'(rd), 32'h04);

    // TX overflow: 9th byte dropped
    for (int i = 0; i < DEPTH; i++) cpu_write(BASE, 8'(8'h10 + i));
    cpu_write(BASE, 8'hEE);
    cpu_read(BASE + 16'd1, rd);
    check("status_ovf", 32'(rd), 32'h12);
    tx_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check("tx_ovf_drain", 32'(tx_data), 32'(8'h10 + i));
      tick(1);
    end
    check("tx_ovf_empty", 32'(tx_valid), 0);
    tx_ready = 1'b0;
    cpu_write(BASE + 16'd3, 8'h02);
    cpu_read(BASE + 16'd1, rd);
    check("status_ovf_cleared", 32'(rd), 32'h04);

    // Full push with simultaneous sink pop succeeds
    for (int i = 0; i < DEPTH; i++) cpu_write(BASE, 8'(8'h20 + i));
    tx_ready = 1'b1;
    cpu_write(BASE, 8'hEE);
    tx_ready = 1'b0;
    cpu_read(BASE + 16'd1, rd);
    check("status_full_no_ovf", 32'(rd), 32'h02);
    tx_ready = 1'b1;
    for (int i = 1; i < DEPTH; i++) begin
      check("tx_pass_drain", 32'(tx_data), 32'(8'h20 + i));
      tick(1);
    end
    check("tx_ee_accepted", 32'(tx_data), 32'hEE);
    tick(1);
    check("tx_pass_empty", 32'(tx_valid), 0);
    tx_ready = 1'b0;

    // Interrupts
    cpu_write(BASE + 16'd2, 8'h01);
    src_push(8'h5A);
    check("irq_one_after_push", 32'(irq), 0);
    tick(1);
    check("irq_two_after_push", 32'(irq), 1);
    cpu_read(BASE, rd);
    check("irq_rx_data", 32'(rd), 32'h5A);
    check("irq_lag_pop", 32'(irq), 1);
    tick(1);
    check("irq_cleared", 32'(irq), 0);
    cpu_write(BASE + 16'd2, 8'h02);
    tick(1);
    check("irq_tx_empty", 32'(irq), 1);
    cpu_write(BASE + 16'd2, 8'h00);
    tick(1);
    check("irq_off", 32'(irq), 0);

    // Misses and write-only on combined strobes
    src_push(8'h44);
    cpu_write(16'hFF04, 8'h77);
    cpu_write(16'h0000, 8'h03);
    cpu_write(16'hFF06, 8'h03);
    cpu_read(16'hFF04, rd);
    check("miss_read_data", 32'(rd), 0);
    cpu_read(16'h0000, rd);
    check("miss_read_zero", 32'(rd), 0);
    check("miss_tx_valid", 32'(tx_valid), 0);
    cpu_read(BASE + 16'd2, rd);
    check("miss_ctrl", 32'(rd), 32'h00);
    cpu_read(BASE + 16'd1, rd);
    check("miss_status", 32'(rd), 32'h05);
    cpu_both(BASE + 16'd2, 8'h01);
    cpu_read(BASE + 16'd2, rd);
    check("both_is_write", 32'(rd), 32'h01);
    cpu_write(BASE + 16'd2, 8'h00);

    // Reset mid-stream
    src_push(8'h91);
    cpu_write(BASE, 8'h61);
    cpu_write(BASE, 8'h62);
    rx_data = 8'h92; rx_valid = 1'b1; tx_ready = 1'b1;
    reset = 1'b0;
    tick(1);
    reset = 1'b1; rx_valid = 1'b0; tx_ready = 1'b0;
    check("mid_rst_tx_valid", 32'(tx_valid), 0);
    check("mid_rst_rx_ready", 32'(rx_ready), 1);
    check("mid_rst_irq", 32'(irq), 0);
    cpu_read(BASE + 16'd1, rd);
    check("mid_rst_status", 32'(rd), 32'h04);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
